// File: rtl/bcd_to_hex_converter.sv
// Iterative BCD-to-binary converter: reverse double-dabble, one result bit per clock.
// Optional digit validity check enabled by defining BCD_TO_HEX_DIGIT_CHECK_EN.
module bcd_to_hex_converter #(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W);

   // Handshake: start is sampled only in IDLE; busy is high for the BIN_W
   // shift cycles; done is a one-cycle pulse in the cycle bin_out/err change.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   sr_next;
   logic [CNT_W-1:0]  cnt;

   // One reverse double-dabble step: shift right, then pull every BCD digit
   // that reached 8 or more back down by 3.
   always_comb begin
      sr_next = sr >> 1;
      for (int k = 0; k < DIGITS; k++) begin
         if (sr_next[BIN_W+4*k +: 4] >= 4'd8)
            sr_next[BIN_W+4*k +: 4] = sr_next[BIN_W+4*k +: 4] - 4'd3;
      end
   end

`ifdef BCD_TO_HEX_DIGIT_CHECK_EN
   logic bcd_bad;
   logic err_q;

   always_comb begin
      bcd_bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_in[4*k +: 4] > 4'd9)
            bcd_bad = 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin_out <= '0;
         sr      <= '0;
         cnt     <= '0;
`ifdef BCD_TO_HEX_DIGIT_CHECK_EN
         err_q   <= 1'b0;
         err     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sr    <= {bcd_in, {BIN_W{1'b0}}};
                  cnt   <= CNT_W'(BIN_W - 1);
                  busy  <= 1'b1;
                  state <= SHIFT;
`ifdef BCD_TO_HEX_DIGIT_CHECK_EN
                  err_q <= bcd_bad;
`endif
               end
            end
            SHIFT: begin
               sr <= sr_next;
               if (cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef BCD_TO_HEX_DIGIT_CHECK_EN
                  bin_out <= err_q ? '0 : sr_next[BIN_W-1:0];
                  err     <= err_q;
`else
                  bin_out <= sr_next[BIN_W-1:0];
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_to_hex_converter.md
Name: bcd_to_hex_converter

Overview:
- Sequential BCD-to-binary converter: the inverse of the hex-to-BCD conversion path.
- Accepts an 8-digit packed BCD value, e.g. from a switch or keypad entry stage. Produces the binary value feeding the counter/preload logic.
- Uses iterative reverse double-dabble (shift right, subtract 3 from digits >= 8): one bit per clock, start/busy/done handshake.

Parameters:
- DIGITS, 8, number of BCD digits in bcd_in; bcd_in width = 4*DIGITS.
- BIN_W, 27, result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (27 for 8 digits); also the number of shift iterations.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 (units) at [3:0], digit k at [4k+3:4k].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err are updated.
- bin_out  output  BIN_W  binary result; held until the next completed conversion.
- err  output  1  invalid BCD digit seen in the last accepted operand (see Optional Feature).

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; busy=0, done=0, bin_out=0, err=0; internal shift register and iteration counter cleared. Reset wins over every other input, including mid-conversion. An aborted conversion leaves no result and produces no done.
- FSM states:
  - IDLE: busy=0. If start=1 at edge t: latch bcd_in into the upper 4*DIGITS bits of a {bcd, bin} shift register (bin part=0); counter=BIN_W-1; go to SHIFT.
  - SHIFT: busy=1. Each cycle, shift the whole {bcd, bin} register right by 1. Then, in the shifted bcd field, any digit >= 8 becomes digit-3 (all digits in parallel, same cycle). If counter==0, go to DONE; else decrement counter.
  - DONE: busy=0, done=1 for exactly this cycle; bin_out=bin field. Always returns to IDLE next cycle.
- Latency: start sampled at edge t. busy high in cycles t+1..t+BIN_W. done high in cycle t+BIN_W+1 (t+28 with defaults). Minimum spacing between accepted starts is BIN_W+2 cycles.
- start while busy=1 or in DONE: ignored, not queued. bcd_in changes after the accepting edge have no effect.
- bin_out and err update only in the DONE cycle (registered, glitch-free). They are stable at all other times.
- Arithmetic: the 4-bit digit correction never underflows, since it applies only to digits >= 8. The bcd field is all-zero after BIN_W shifts for any valid input.
- Boundaries:
  - all-zero input -> bin_out=0.
  - max input 99999999 -> 0x5F5E0FF with no overflow.
  - start held high continuously -> back-to-back conversions every BIN_W+2 cycles.

Optional Feature:
- Macro: BCD_TO_HEX_DIGIT_CHECK_EN.
- Defined: at the accepting edge, each digit of bcd_in is checked for > 9. If any fails, err=1 is latched for this operand. The conversion still runs with identical latency; at DONE, err=1 and bin_out is forced to 0. With all digits valid, err=0.
- Undefined: no checking logic. err is tied to 0. Invalid digits produce an unspecified bin_out with the same latency and handshake.

Test Plan:
- Reset then start with bcd_in=0x12345678 -> busy high 27 cycles; done pulse at t+28; bin_out=0x0BC614E; err=0.
- bcd_in=0x99999999 -> bin_out=0x5F5E0FF. Then bcd_in=0x00000000 -> bin_out=0. Then 0x00000010 -> 0x00000A.
- During a conversion of 0x00000255, pulse start with bcd_in=0x00000001 -> ignored; result 0x0FF, single done pulse.
- Assert reset at cycle t+10 of a conversion -> busy=0, bin_out=0 next cycle; no done pulse. A fresh start afterwards completes normally.
- With BCD_TO_HEX_DIGIT_CHECK_EN: bcd_in=0x0000001A -> done at t+28, err=1, bin_out=0. Next valid operand 0x00000042 -> err=0, bin_out=0x2A.
- start held high with bcd_in=0x00000007 -> done pulses every 29 cycles, bin_out=7 each time.
